// File: rtl/register_move_sequencer_if.sv
// Command handshake bundle for the register move sequencer.
// The master offers src/dst/imm commands; the slave returns buffer-not-full.
interface register_move_sequencer_if;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [4:0] i_cmd_src;
    logic [4:0] i_cmd_dst;
    logic [7:0] i_cmd_imm;

    modport master (output i_cmd_valid, i_cmd_src, i_cmd_dst, i_cmd_imm, input o_cmd_ready);
    modport slave  (input i_cmd_valid, i_cmd_src, i_cmd_dst, i_cmd_imm, output o_cmd_ready);
endinterface

// File: rtl/register_move_sequencer.sv
// Buffers register-move commands and sequences each one onto an 8-bit bus:
// assert the source, pulse the destination load, hold, then report done/err.
module register_move_sequencer #(
    parameter int  FIFO_DEPTH  = 4,
    parameter int  HOLD_CYCLES = 1,
    localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    register_move_sequencer_if.slave cmd,
    output logic [4:0]               o_8bit_assert_word,
    output logic [4:0]               o_8bit_load_word,
    output logic [7:0]               o_bus_in,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    output logic [CW-1:0]            o_count
);
    localparam int            PW        = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [1:0]    HOLD_INIT = 2'(HOLD_CYCLES - 1);

    typedef struct packed {
        logic [4:0] src;
        logic [4:0] dst;
        logic [7:0] imm;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, FETCH, SETUP, LOAD, HOLD, DONE} state_t;

    cmd_t          mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          push, pop, legal;
    cmd_t          head;
    state_t        state;
    logic [4:0]    wdst;
    logic [1:0]    hold_cnt;

    assign push  = cmd.i_cmd_valid && cmd.o_cmd_ready;
    assign pop   = (state == FETCH);
    assign head  = mem[rd_ptr];
    assign legal = (head.src <= 5'd5) && (head.dst != 5'd0) && (head.dst <= 5'd5) &&
                   (head.src != head.dst);

    always_comb begin
        count_nxt = o_count;
        if (push && !pop)      count_nxt = o_count + 1'b1;
        else if (!push && pop) count_nxt = o_count - 1'b1;
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd.i_cmd_src, cmd.i_cmd_dst, cmd.i_cmd_imm};
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            o_count         <= '0;
            cmd.o_cmd_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            o_count         <= count_nxt;
            cmd.o_cmd_ready <= (count_nxt < DEPTH_C);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            o_8bit_assert_word <= '0;
            o_8bit_load_word   <= '0;
            o_bus_in           <= '0;
            o_busy             <= 1'b0;
            o_done             <= 1'b0;
            o_err              <= 1'b0;
            wdst               <= '0;
            hold_cnt           <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            o_busy <= 1'b1;
            case (state)
                IDLE: begin
                    if (o_count != '0) state <= FETCH;
                    else               o_busy <= (count_nxt != '0);
                end
                FETCH: begin
                    if (legal) begin
                        state              <= SETUP;
                        o_8bit_assert_word <= head.src;
                        o_bus_in           <= (head.src == 5'd0) ? head.imm : 8'h00;
                        wdst               <= head.dst;
                    end else begin
                        state  <= IDLE;
                        o_err  <= 1'b1;
                        o_busy <= (count_nxt != '0);
                    end
                end
                SETUP: begin
                    state            <= LOAD;
                    o_8bit_load_word <= wdst;
                end
                LOAD: begin
                    state            <= HOLD;
                    o_8bit_load_word <= '0;
                    hold_cnt         <= HOLD_INIT;
                end
                HOLD: begin
                    if (hold_cnt == 2'd0) begin
                        state              <= DONE;
                        o_8bit_assert_word <= '0;
                        o_bus_in           <= '0;
                        o_done             <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 2'd1;
                    end
                end
                DONE: begin
                    // Go straight back to FETCH so queued moves run without an IDLE bubble.
                    if (o_count != '0) state <= FETCH;
                    else begin
                        state  <= IDLE;
                        o_busy <= (count_nxt != '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
